alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Two-stage pipelined issue/writeback wrapper around the 16-bit combinational ALU (`alu_16bit`).
- Stage 1 (S1) accepts an operation via valid/ready, decodes a 4-bit function code into the ALU control lines, and drives registered operands into the ALU.
- Stage 2 (S2) captures the ALU outputs, adds overflow and set-less-than results, and presents a registered result via valid/ready.

The block sits between the instruction decode/operand fetch logic and register-file writeback.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried with each operation.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `in_a`, `in_b`  in  16  operands.
- `in_func`  in  4  function code (see Operation).
- `in_tag`  in  `TAG_W`  tag; returned unchanged on `out_tag`.
- `alu_a`, `alu_b`  out  16  operands to the ALU, from S1 registers.
- `alu_cin`, `alu_ainvert`, `alu_bnegate`  out  1 each  ALU controls, from S1 registers.
- `alu_op`  out  3  ALU operation select, from S1 registers.
- `alu_result`  in  16  ALU result.
- `alu_cout`  in  1  ALU carry out.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  16  final result.
- `out_cout`  out  1  final carry out.
- `out_zero`  out  1  final zero flag.
- `out_overflow`  out  1  signed overflow.
- `out_err`  out  1  illegal function code.
- `out_tag`  out  `TAG_W`  tag of the result.

## Operation
Decode of `in_func` into {`ainvert`, `bnegate`, `cin`, `op`}, registered into S1 on accept:
- 0 AND: {0,0,0,000}
- 1 OR: {0,0,0,001}
- 2 ADD: {0,0,0,010}
- 3 SUB: {0,1,1,010}
- 4 NOR: {1,1,0,000}
- 5 NAND: {1,1,0,001}
- 6 SLT: {0,1,1,010}
- 7–15: illegal. Controls are {0,0,0,000}; an illegal flag is held in S1.

S1 also holds the operands, the function code, the tag and `s1_valid`. `alu_*` outputs always reflect the S1 registers, including when S1 is empty.

S2 capture, from S1 and the ALU inputs, with r = `alu_result`:
- Overflow, ADD: (a[15]==b[15]) && (r[15]!=a[15]).
- Overflow, SUB: (a[15]!=b[15]) && (r[15]!=a[15]).
- Overflow for all other codes is 0.
- SLT: `out_result` = {15'b0, r[15]^ovf_sub}. `out_overflow` = 0. `out_zero` = (`out_result` == 0). `out_cout` = `alu_cout`.
- Illegal codes: `out_result` = 0, `out_cout` = 0, `out_zero` = 1, `out_overflow` = 0, `out_err` = 1.
- All other codes: `out_result` = r, `out_cout` = `alu_cout`, `out_zero` = `alu_zero`, `out_err` = 0.

Handshake and flow control:
- `s2_free` = !`s2_valid` || `out_ready`.
- `in_ready` = !`s1_valid` || `s2_free`. It is combinational and never depends on `in_valid`.
- S1→S2 transfer when `s1_valid` && `s2_free`.
- S1 load when `in_valid` && `in_ready`.
- Per edge, `s2_valid` becomes `s1_valid` when `s2_free`, else it holds.
- Per edge, `s1_valid` becomes `in_valid` when `in_ready`, else it holds.
- Payload registers load only on their transfer. Holding registers do not change. `out_*` are stable while `out_valid` && !`out_ready`.
- Simultaneous accept, transfer and drain in one cycle is legal and gives full throughput: one operation per cycle.
- Order is strictly preserved. No operation is dropped or duplicated.

Reset (`rst_n` low, asynchronous, at any time including mid-stream):
- `s1_valid` = 0 and `s2_valid` = 0, so `out_valid` = 0.
- All S1 and S2 payload registers clear to 0. As a result, all `alu_*` outputs and all `out_*` outputs are 0.
- `in_ready` = 1 while in reset and after release.
- In-flight operations are discarded.

## Timing
- Latency: an operation accepted at edge N drives the ALU during cycle N→N+1, is captured at edge N+1, and `out_valid` is high after edge N+1. Minimum latency is 1 cycle accept→`out_valid`, 2 edges from input presentation to output acceptance.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Under sustained `out_ready` = 0, exactly 2 operations are buffered. `in_ready` falls after the second accept.
- `in_ready` rises combinationally in the same cycle `out_ready` rises.
- The ALU path (S1 registers → `alu_16bit` → S2 registers) is a single-cycle combinational path.

## Test plan
- Reset: assert `rst_n` = 0 with S1 and S2 both full → immediately `out_valid` = 0, `in_ready` = 1, `out_result` = 0. Release, send ADD 1+1 → `out_result` = 0x0002.
- Add/sub:
  - ADD 0x000F+0x000E → 0x001D, cout 0, zero 0, ovf 0.
  - SUB 0x000F−0x000E → 0x0001, cout 1.
  - SUB 1001−12341 → 0xD3B4, cout 0, ovf 0.
- Overflow/SLT:
  - ADD 0x7FFF+0x0001 → 0x8000, ovf 1.
  - SLT a=0x8000, b=0x0001 → 0x0001, ovf 0.
  - SLT a=0x0005, b=0x0003 → 0x0000, zero 1.
- Logic: NOR 2,1 → 0xFFFC. NAND 0xFFFF,0x00FF → 0xFF00. AND 0,0 → 0, zero 1.
- Backpressure: stream tags 1..5 with `out_ready` = 0 for 3 cycles → `in_ready` drops after tags 1 and 2 are accepted, `out_*` stay stable. Release → tags emerge 1..5 in order, each exactly once.
- Illegal: `in_func` = 9, a=0x1234 → `out_err` = 1, `out_result` = 0, `out_zero` = 1. The following legal op has `out_err` = 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/writeback wrapper around the external
// 16-bit combinational ALU (alu_16bit).
//   S1: accepts an operation, decodes the function code into ALU control
//       lines and drives registered operands/controls to the ALU.
//   S2: captures the ALU outputs, derives overflow / set-less-than / illegal
//       handling and presents a registered result downstream.
// Both stages use valid/ready with a combinational ready chain, so the
// pipeline sustains one operation per cycle and buffers exactly two under
// sustained downstream backpressure.

module alu_issue_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  // Upstream (decode / operand fetch)
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [3:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,

  // External ALU
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_cin,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [15:0]      alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,

  // Downstream (register-file writeback)
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  // Function codes accepted on in_func; 7..15 are illegal.
  typedef enum logic [3:0] {
    FN_AND  = 4'd0,
    FN_OR   = 4'd1,
    FN_ADD  = 4'd2,
    FN_SUB  = 4'd3,
    FN_NOR  = 4'd4,
    FN_NAND = 4'd5,
    FN_SLT  = 4'd6
  } func_e;

  // ALU operation select encoding.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [15:0]      r_s1_a;
  logic [15:0]      r_s1_b;
  logic [3:0]       r_s1_func;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_ainvert;
  logic             r_s1_bnegate;
  logic             r_s1_cin;
  logic [2:0]       r_s1_op;
  logic             r_s1_illegal;

  logic             r_s2_valid;
  logic [15:0]      r_s2_result;
  logic             r_s2_cout;
  logic             r_s2_zero;
  logic             r_s2_overflow;
  logic             r_s2_err;
  logic [TAG_W-1:0] r_s2_tag;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_s2_free;
  logic w_s1_load;
  logic w_s1_to_s2;

  // S2 can take new data when empty or when its result leaves this cycle;
  // S1 can take new data when empty or when it hands off to S2 this cycle.
  assign w_s2_free  = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_s1_load  = in_valid && in_ready;
  assign w_s1_to_s2 = r_s1_valid && w_s2_free;

  // ---------------------------------------------------------------------------
  // Function decode
  // ---------------------------------------------------------------------------
  logic       w_dec_ainvert;
  logic       w_dec_bnegate;
  logic       w_dec_cin;
  logic [2:0] w_dec_op;
  logic       w_dec_illegal;

  // Translate the function code into ALU control lines.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    w_dec_ainvert = 1'b0;
    w_dec_bnegate = 1'b0;
    w_dec_cin     = 1'b0;
    w_dec_op      = ALU_AND;
    w_dec_illegal = 1'b0;
    case (in_func)
      FN_AND: w_dec_op = ALU_AND;
      FN_OR:  w_dec_op = ALU_OR;
      FN_ADD: w_dec_op = ALU_ADD;
      FN_SUB, FN_SLT: begin
        // a + ~b + 1 = a - b; SLT reuses the subtract and inspects the sign.
        w_dec_bnegate = 1'b1;
        w_dec_cin     = 1'b1;
        w_dec_op      = ALU_ADD;
      end
      FN_NOR: begin
        // ~a & ~b = ~(a | b)
        w_dec_ainvert = 1'b1;
        w_dec_bnegate = 1'b1;
        w_dec_op      = ALU_AND;
      end
      FN_NAND: begin
        // ~a | ~b = ~(a & b)
        w_dec_ainvert = 1'b1;
        w_dec_bnegate = 1'b1;
        w_dec_op      = ALU_OR;
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------

  // S1 occupancy: refilled (or emptied) whenever S1 is able to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      // NOTE: clocked state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      r_s1_valid <= in_valid;
    end
  end

  // S1 payload: loads only on an accepted operation, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload is reset as well because the ALU control outputs and
      // the downstream result must read as zero during and after reset.
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_func    <= '0;
      r_s1_tag     <= '0;
      r_s1_ainvert <= 1'b0;
      r_s1_bnegate <= 1'b0;
      r_s1_cin     <= 1'b0;
      r_s1_op      <= '0;
      r_s1_illegal <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_a       <= in_a;
      r_s1_b       <= in_b;
      r_s1_func    <= in_func;
      r_s1_tag     <= in_tag;
      r_s1_ainvert <= w_dec_ainvert;
      r_s1_bnegate <= w_dec_bnegate;
      r_s1_cin     <= w_dec_cin;
      r_s1_op      <= w_dec_op;
      r_s1_illegal <= w_dec_illegal;
    end
  end

  // The ALU always sees the S1 registers, valid or not.
  assign alu_a       = r_s1_a;
  assign alu_b       = r_s1_b;
  assign alu_cin     = r_s1_cin;
  assign alu_ainvert = r_s1_ainvert;
  assign alu_bnegate = r_s1_bnegate;
  assign alu_op      = r_s1_op;

  // ---------------------------------------------------------------------------
  // S2 result formation (combinational, from S1 registers and ALU outputs)
  // ---------------------------------------------------------------------------
  logic        w_ovf_add;
  logic        w_ovf_sub;
  logic        w_slt_bit;
  logic [15:0] w_s2_result;
  logic        w_s2_cout;
  logic        w_s2_zero;
  logic        w_s2_overflow;
  logic        w_s2_err;

  // Signed overflow uses the original operands, not the inverted ALU inputs.
  assign w_ovf_add = (r_s1_a[15] == r_s1_b[15]) && (alu_result[15] != r_s1_a[15]);
  assign w_ovf_sub = (r_s1_a[15] != r_s1_b[15]) && (alu_result[15] != r_s1_a[15]);
  // a < b (signed) is the sign of a-b corrected for overflow.
  assign w_slt_bit = alu_result[15] ^ w_ovf_sub;

  // Select the final result and flags according to the S1 function code.
  always_comb begin
    w_s2_result   = alu_result;
    w_s2_cout     = alu_cout;
    w_s2_zero     = alu_zero;
    w_s2_overflow = 1'b0;
    w_s2_err      = 1'b0;
    if (r_s1_illegal) begin
      w_s2_result = '0;
      w_s2_cout   = 1'b0;
      w_s2_zero   = 1'b1;
      w_s2_err    = 1'b1;
    end else begin
      case (r_s1_func)
        FN_ADD: w_s2_overflow = w_ovf_add;
        FN_SUB: w_s2_overflow = w_ovf_sub;
        FN_SLT: begin
          w_s2_result = {15'b0, w_slt_bit};
          w_s2_zero   = !w_slt_bit;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------

  // S2 occupancy: follows S1 whenever S2 is free, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  // S2 payload: loads only on an S1->S2 transfer so outputs hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_result   <= '0;
      r_s2_cout     <= 1'b0;
      r_s2_zero     <= 1'b0;
      r_s2_overflow <= 1'b0;
      r_s2_err      <= 1'b0;
      r_s2_tag      <= '0;
    end else if (w_s1_to_s2) begin
      r_s2_result   <= w_s2_result;
      r_s2_cout     <= w_s2_cout;
      r_s2_zero     <= w_s2_zero;
      r_s2_overflow <= w_s2_overflow;
      r_s2_err      <= w_s2_err;
      r_s2_tag      <= r_s1_tag;
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_result   = r_s2_result;
  assign out_cout     = r_s2_cout;
  assign out_zero     = r_s2_zero;
  assign out_overflow = r_s2_overflow;
  assign out_err      = r_s2_err;
  assign out_tag      = r_s2_tag;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: behavioural alu_16bit stand-in, directed
// and randomized stimulus, reference model feeding a scoreboard queue, and
// an independent monitor that checks every result the DUT hands downstream.

module tb_alu_issue_stage;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [3:0]       in_func;
  logic [TAG_W-1:0] in_tag;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic             alu_cin;
  logic             alu_ainvert;
  logic             alu_bnegate;
  logic [2:0]       alu_op;
  logic [15:0]      alu_result;
  logic             alu_cout;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic             out_cout;
  logic             out_zero;
  logic             out_overflow;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  alu_issue_stage #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_func      (in_func),
    .in_tag       (in_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_ainvert  (alu_ainvert),
    .alu_bnegate  (alu_bnegate),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_cout     (out_cout),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_err      (out_err),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  // Behavioural alu_16bit: optional inversion of each input, then AND / OR /
  // add-with-carry; carry-out is only meaningful for the add.
  logic [15:0] alu_xa;
  logic [15:0] alu_xb;
  logic [16:0] alu_sum;
  always_comb begin
    alu_xa  = alu_ainvert ? ~alu_a : alu_a;
    alu_xb  = alu_bnegate ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_xa} + {1'b0, alu_xb} + {16'b0, alu_cin};
    case (alu_op)
      3'b000:  alu_result = alu_xa & alu_xb;
      3'b001:  alu_result = alu_xa | alu_xb;
      3'b010:  alu_result = alu_sum[15:0];
      default: alu_result = 16'h0000;
    endcase
    alu_cout = (alu_op == 3'b010) ? alu_sum[16] : 1'b0;
    alu_zero = (alu_result == 16'h0000);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0]      result;
    logic             cout;
    logic             zero;
    logic             ovf;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what each function code means arithmetically.
  function automatic exp_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] f, input logic [TAG_W-1:0] tag);
    exp_t        e;
    int          sa;
    int          sb;
    int          sr;
    logic [16:0] wide;
    sa       = $signed(a);
    sb       = $signed(b);
    e.result = 16'h0000;
    e.cout   = 1'b0;
    e.ovf    = 1'b0;
    e.err    = 1'b0;
    e.tag    = tag;
    case (f)
      4'd0: e.result = a & b;
      4'd1: e.result = a | b;
      4'd2: begin
        wide     = {1'b0, a} + {1'b0, b};
        e.result = wide[15:0];
        e.cout   = wide[16];
        sr       = sa + sb;
        e.ovf    = (sr > 32767) || (sr < -32768);
      end
      4'd3: begin
        e.result = a - b;
        e.cout   = (a >= b);
        sr       = sa - sb;
        e.ovf    = (sr > 32767) || (sr < -32768);
      end
      4'd4: e.result = ~(a | b);
      4'd5: e.result = ~(a & b);
      4'd6: begin
        e.result = (sa < sb) ? 16'h0001 : 16'h0000;
        e.cout   = (a >= b);
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == 16'h0000);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Downstream ready generation
  // ---------------------------------------------------------------------------
  logic force_ready = 1'b1;
  logic rand_ready  = 1'b0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: checks each accepted result and stability while stalled
  // ---------------------------------------------------------------------------
  initial begin
    exp_t snap;
    exp_t cur;
    exp_t e;
    logic holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{out_result, out_cout, out_zero, out_overflow, out_err, out_tag};
      if (!rst_n || !out_valid) begin
        holding = 1'b0;
      end else begin
        if (holding) check("stall_stable", 32'(cur), 32'(snap));
        if (out_ready) begin
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: tag %0d with no pending operation", out_tag);
          end else begin
            e = exp_q.pop_front();
            check("tag",      out_tag,      e.tag);
            check("result",   out_result,   e.result);
            check("cout",     out_cout,     e.cout);
            check("zero",     out_zero,     e.zero);
            check("overflow", out_overflow, e.ovf);
            check("err",      out_err,      e.err);
          end
        end else begin
          holding = 1'b1;
          snap    = cur;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Presents one operation, waits (bounded) for acceptance, records the
  // expected result; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f, input logic [TAG_W-1:0] t);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_func  = f;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_op(a, b, f, t));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [3:0] f;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_func  = '0;
    in_tag   = '0;
    #1 rst_n = 1'b0;
    #1;
    check("por_out_valid", out_valid, 1'b0);
    check("por_in_ready",  in_ready,  1'b1);
    check("por_alu_op",    alu_op,    3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Fill both stages under backpressure, then reset mid-stream.
    force_ready = 1'b0;
    idle(1);
    send(16'h1234, 16'h0101, 4'd2, 4'd7);
    send(16'h00FF, 16'hFF00, 4'd1, 4'd9);
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready",  in_ready,  1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_in_ready",   in_ready,   1'b1);
    check("rst_out_result", out_result, 16'h0000);
    check("rst_out_tag",    out_tag,    4'd0);
    check("rst_alu_a",      alu_a,      16'h0000);
    check("rst_alu_ctrl",   {alu_ainvert, alu_bnegate, alu_cin, alu_op}, 6'd0);
    exp_q.delete();
    force_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1'b1);
    idle(1);

    // Directed operations from the test plan.
    send(16'h0001, 16'h0001, 4'd2, 4'd1);
    send(16'h000F, 16'h000E, 4'd2, 4'd2);
    send(16'h000F, 16'h000E, 4'd3, 4'd3);
    send(16'd1001, 16'd12341, 4'd3, 4'd4);
    send(16'h7FFF, 16'h0001, 4'd2, 4'd5);
    send(16'h8000, 16'h0001, 4'd6, 4'd6);
    send(16'h0005, 16'h0003, 4'd6, 4'd7);
    send(16'h0002, 16'h0001, 4'd4, 4'd8);
    send(16'hFFFF, 16'h00FF, 4'd5, 4'd9);
    send(16'h0000, 16'h0000, 4'd0, 4'd10);
    send(16'h8000, 16'h0001, 4'd3, 4'd11);
    send(16'h1234, 16'h5678, 4'd9, 4'd12);
    send(16'h0003, 16'h0004, 4'd2, 4'd13);
    idle(3);

    // Backpressure: two ops buffer, in_ready falls, outputs hold.
    force_ready = 1'b0;
    idle(1);
    send(16'h0010, 16'h0001, 4'd2, 4'd1);
    send(16'h0020, 16'h0002, 4'd3, 4'd2);
    in_valid = 1'b1;
    in_a     = 16'h0030;
    in_b     = 16'h0003;
    in_func  = 4'd1;
    in_tag   = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_head_tag",     out_tag,  4'd1);
    end
    @(posedge clk);
    #1;
    force_ready = 1'b1;
    send(16'h0030, 16'h0003, 4'd1, 4'd3);
    send(16'h0040, 16'h0004, 4'd0, 4'd4);
    send(16'h0050, 16'h0005, 4'd6, 4'd5);
    idle(4);

    // Randomized traffic with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) f = 4'($urandom_range(7, 15));
      else                           f = 4'($urandom_range(0, 6));
      send(pick(), pick(), f, 4'(i));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    in_valid = 1'b0;

    // Drain with ready held high.
    rand_ready  = 1'b0;
    force_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
